// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the serial convolution scheduler (conv_sched) and its
// tap counter chain (conv_tap_cnt):
//   - default layer geometry (image size, kernel size, kernel count)
//   - derived output geometry and total tap count for the defaults
//   - counter/address width localparams for the defaults
//   - the layer FSM state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package conv_pkg;

  // Width of a counter that must hold 0..v-1; never narrower than one bit so
  // that degenerate sizes (v = 1) still give legal vectors.
  function automatic int clog2w(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

  localparam int DEF_IMG_X    = 28;
  localparam int DEF_IMG_Y    = 28;
  localparam int DEF_KER      = 5;
  localparam int DEF_N_KERNEL = 8;

  localparam int DEF_OUT_X = DEF_IMG_X - DEF_KER + 1;
  localparam int DEF_OUT_Y = DEF_IMG_Y - DEF_KER + 1;
  localparam int DEF_T     = DEF_N_KERNEL * DEF_OUT_X * DEF_OUT_Y * DEF_KER * DEF_KER;

  localparam int DEF_DX_W = clog2w(DEF_IMG_X);
  localparam int DEF_DY_W = clog2w(DEF_IMG_Y);
  localparam int DEF_K_W  = clog2w(DEF_N_KERNEL);
  localparam int DEF_T_W  = clog2w(DEF_KER);
  localparam int DEF_OX_W = clog2w(DEF_OUT_X);
  localparam int DEF_OY_W = clog2w(DEF_OUT_Y);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/conv_tap_cnt.sv
// ---------------------------------------------------------------------------
// conv_tap_cnt
// Nested wrap/carry counter chain that walks every tap of a convolution layer
// in the order kernel, x, y, i, j (outermost to innermost).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         synchronous return of every counter to 0
//   advance       step to the next tap (j increments, carries outward)
//   kernel,x,y    current kernel and output position
//   i,j           current tap inside the KER x KER window
//   first_tap     current tap is i=0, j=0 (window start)
//   last_tap      current tap is i=KER-1, j=KER-1 (window end)
//   last_all      current tap is the final tap of the whole layer
// ---------------------------------------------------------------------------
module conv_tap_cnt
  import conv_pkg::*;
#(
  parameter int N_KERNEL = DEF_N_KERNEL,
  parameter int OUT_X    = DEF_OUT_X,
  parameter int OUT_Y    = DEF_OUT_Y,
  parameter int KER      = DEF_KER
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         advance,
  output logic [clog2w(N_KERNEL)-1:0]  kernel,
  output logic [clog2w(OUT_X)-1:0]     x,
  output logic [clog2w(OUT_Y)-1:0]     y,
  output logic [clog2w(KER)-1:0]       i,
  output logic [clog2w(KER)-1:0]       j,
  output logic                         first_tap,
  output logic                         last_tap,
  output logic                         last_all
);

  localparam int NKW = clog2w(N_KERNEL);
  localparam int XW  = clog2w(OUT_X);
  localparam int YW  = clog2w(OUT_Y);
  localparam int TW  = clog2w(KER);

  localparam logic [NKW-1:0] K_LAST = NKW'(N_KERNEL - 1);
  localparam logic [XW-1:0]  X_LAST = XW'(OUT_X - 1);
  localparam logic [YW-1:0]  Y_LAST = YW'(OUT_Y - 1);
  localparam logic [TW-1:0]  T_LAST = TW'(KER - 1);

  localparam logic [NKW-1:0] K_ONE = NKW'(1);
  localparam logic [XW-1:0]  X_ONE = XW'(1);
  localparam logic [YW-1:0]  Y_ONE = YW'(1);
  localparam logic [TW-1:0]  T_ONE = TW'(1);

  logic j_wrap_s;
  logic i_wrap_s;
  logic y_wrap_s;
  logic x_wrap_s;

  assign j_wrap_s = (j == T_LAST);
  assign i_wrap_s = (i == T_LAST);
  assign y_wrap_s = (y == Y_LAST);
  assign x_wrap_s = (x == X_LAST);

  assign first_tap = (i == {TW{1'b0}}) && (j == {TW{1'b0}});
  assign last_tap  = i_wrap_s && j_wrap_s;
  assign last_all  = last_tap && y_wrap_s && x_wrap_s && (kernel == K_LAST);

  // Counter chain: each level wraps at its limit and carries one level out.
  // The final advance of a layer wraps everything back to 0.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      kernel <= {NKW{1'b0}};
      x      <= {XW{1'b0}};
      y      <= {YW{1'b0}};
      i      <= {TW{1'b0}};
      j      <= {TW{1'b0}};
    end else if (advance) begin
      if (j_wrap_s) begin
        j <= {TW{1'b0}};
        if (i_wrap_s) begin
          i <= {TW{1'b0}};
          if (y_wrap_s) begin
            y <= {YW{1'b0}};
            if (x_wrap_s) begin
              x      <= {XW{1'b0}};
              kernel <= (kernel == K_LAST) ? {NKW{1'b0}} : kernel + K_ONE;
            end else begin
              x <= x + X_ONE;
            end
          end else begin
            y <= y + Y_ONE;
          end
        end else begin
          i <= i + T_ONE;
        end
      end else begin
        j <= j + T_ONE;
      end
    end else begin
      kernel <= kernel;
    end
  end

endmodule

// File: rtl/conv_sched.sv
// ---------------------------------------------------------------------------
// conv_sched
// Sequencer for a time-multiplexed convolution engine. For every kernel and
// output position it issues one image/weight read per tap, drives clear/enable
// to a single shared MAC one cycle later (memory latency is 1), and strobes
// the finished sum into the result store one cycle after the last tap's MAC.
//
// Optional feature macro: CONV_SCHED_STALL_EN
//   defined   : mem_ready=0 while running suppresses rd_en and holds the tap
//               counters; MAC and result stages keep draining.
//   undefined : mem_ready is ignored, the scheduler never stalls.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start                one-cycle request to run a full layer (IDLE only)
//   mem_ready            read memories can accept a read this cycle
//   busy                 run in progress
//   done                 one-cycle pulse when the layer is complete
//   rd_en                read strobe for data and weight memories
//   data_x, data_y       image address x+i, y+j (valid with rd_en)
//   w_kernel, w_i, w_j   weight bank and tap select (valid with rd_en)
//   mac_clear            MAC loads the product instead of accumulating
//   mac_en               MAC operand valid
//   result_we            write accumulated sum
//   res_kernel/x/y       result address (valid with result_we)
// ---------------------------------------------------------------------------
module conv_sched
  import conv_pkg::*;
#(
  parameter int IMG_X    = DEF_IMG_X,
  parameter int IMG_Y    = DEF_IMG_Y,
  parameter int KER      = DEF_KER,
  parameter int N_KERNEL = DEF_N_KERNEL
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                mem_ready,
  output logic                                busy,
  output logic                                done,
  output logic                                rd_en,
  output logic [clog2w(IMG_X)-1:0]            data_x,
  output logic [clog2w(IMG_Y)-1:0]            data_y,
  output logic [clog2w(N_KERNEL)-1:0]         w_kernel,
  output logic [clog2w(KER)-1:0]              w_i,
  output logic [clog2w(KER)-1:0]              w_j,
  output logic                                mac_clear,
  output logic                                mac_en,
  output logic                                result_we,
  output logic [clog2w(N_KERNEL)-1:0]         res_kernel,
  output logic [clog2w(IMG_X-KER+1)-1:0]      res_x,
  output logic [clog2w(IMG_Y-KER+1)-1:0]      res_y
);

  localparam int OUT_X = IMG_X - KER + 1;
  localparam int OUT_Y = IMG_Y - KER + 1;
  localparam int DXW   = clog2w(IMG_X);
  localparam int DYW   = clog2w(IMG_Y);
  localparam int NKW   = clog2w(N_KERNEL);
  localparam int TW    = clog2w(KER);
  localparam int XW    = clog2w(OUT_X);
  localparam int YW    = clog2w(OUT_Y);

  state_t          state_r;
  state_t          next_state_s;
  logic            drain_cnt_r;
  logic            ready_s;
  logic            issue_s;
  logic            cnt_clear_s;

  logic [NKW-1:0]  cnt_k_s;
  logic [XW-1:0]   cnt_x_s;
  logic [YW-1:0]   cnt_y_s;
  logic [TW-1:0]   cnt_i_s;
  logic [TW-1:0]   cnt_j_s;
  logic            first_tap_s;
  logic            last_tap_s;
  logic            last_all_s;

  logic            busy_r;
  logic            done_r;
  logic            mac_en_r;
  logic            mac_clear_r;
  logic            s1_last_r;
  logic [NKW-1:0]  s1_k_r;
  logic [XW-1:0]   s1_x_r;
  logic [YW-1:0]   s1_y_r;
  logic            result_we_r;
  logic [NKW-1:0]  res_k_r;
  logic [XW-1:0]   res_x_r;
  logic [YW-1:0]   res_y_r;

`ifdef CONV_SCHED_STALL_EN
  assign ready_s = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign ready_s          = 1'b1;
`endif

  // A tap is issued in every RUN cycle the memories can accept it.
  assign issue_s     = (state_r == RUN) && ready_s;
  assign cnt_clear_s = (state_r == IDLE) && start;

  conv_tap_cnt #(
    .N_KERNEL (N_KERNEL),
    .OUT_X    (OUT_X),
    .OUT_Y    (OUT_Y),
    .KER      (KER)
  ) u_tap_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear_s),
    .advance   (issue_s),
    .kernel    (cnt_k_s),
    .x         (cnt_x_s),
    .y         (cnt_y_s),
    .i         (cnt_i_s),
    .j         (cnt_j_s),
    .first_tap (first_tap_s),
    .last_tap  (last_tap_s),
    .last_all  (last_all_s)
  );

  // Read side comes straight from the counter registers; x+i never exceeds
  // IMG_X-1 because x stops at OUT_X-1 and i at KER-1.
  assign rd_en    = issue_s;
  assign data_x   = DXW'(cnt_x_s) + DXW'(cnt_i_s);
  assign data_y   = DYW'(cnt_y_s) + DYW'(cnt_j_s);
  assign w_kernel = cnt_k_s;
  assign w_i      = cnt_i_s;
  assign w_j      = cnt_j_s;

  assign busy       = busy_r;
  assign done       = done_r;
  assign mac_en     = mac_en_r;
  assign mac_clear  = mac_clear_r;
  assign result_we  = result_we_r;
  assign res_kernel = res_k_r;
  assign res_x      = res_x_r;
  assign res_y      = res_y_r;

  // Layer FSM next-state; start is only honoured in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (issue_s && last_all_s) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = RUN;
        end
      end
      DRAIN: begin
        // Two cycles: one for the last MAC, one for its result write.
        if (drain_cnt_r) begin
          next_state_s = DONE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register plus busy/done registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      drain_cnt_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      drain_cnt_r <= (state_r == DRAIN) ? ~drain_cnt_r : 1'b0;
      busy_r      <= (next_state_s == RUN) || (next_state_s == DRAIN);
      done_r      <= (next_state_s == DONE);
    end
  end

  // Two-stage pipeline: stage 1 lines up with read data (MAC operands),
  // stage 2 with the accumulated sum of a finished window.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_en_r    <= 1'b0;
      mac_clear_r <= 1'b0;
      s1_last_r   <= 1'b0;
      s1_k_r      <= {NKW{1'b0}};
      s1_x_r      <= {XW{1'b0}};
      s1_y_r      <= {YW{1'b0}};
      result_we_r <= 1'b0;
      res_k_r     <= {NKW{1'b0}};
      res_x_r     <= {XW{1'b0}};
      res_y_r     <= {YW{1'b0}};
    end else begin
      mac_en_r    <= issue_s;
      mac_clear_r <= issue_s && first_tap_s;
      s1_last_r   <= issue_s && last_tap_s;
      s1_k_r      <= cnt_k_s;
      s1_x_r      <= cnt_x_s;
      s1_y_r      <= cnt_y_s;
      result_we_r <= mac_en_r && s1_last_r;
      res_k_r     <= s1_k_r;
      res_x_r     <= s1_x_r;
      res_y_r     <= s1_y_r;
    end
  end

endmodule

// File: tb/tb_conv_sched.sv
// ---------------------------------------------------------------------------
// tb_conv_sched
// Directed bench for conv_sched with a 6x6 image, 3x3 kernel and 2 kernels
// (4x4 outputs, 288 taps per layer). Each task drives one scenario and checks
// the outputs against values computed here from the loop order and the fixed
// pipeline timing. Compile with CONV_SCHED_STALL_EN defined to expect stalls.
// ---------------------------------------------------------------------------
module tb_conv_sched;

  localparam int IX  = 6;
  localparam int IY  = 6;
  localparam int K   = 3;
  localparam int NK  = 2;
  localparam int OX  = IX - K + 1;
  localparam int OY  = IY - K + 1;
  localparam int T   = NK * OX * OY * K * K;
  localparam int NWIN = NK * OX * OY;
  localparam int DXW = 3;
  localparam int DYW = 3;
  localparam int NKW = 1;
  localparam int TW  = 2;
  localparam int XW  = 2;
  localparam int YW  = 2;
  localparam int N_STALL = 10;
`ifdef CONV_SCHED_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           mem_ready;
  logic           busy;
  logic           done;
  logic           rd_en;
  logic [DXW-1:0] data_x;
  logic [DYW-1:0] data_y;
  logic [NKW-1:0] w_kernel;
  logic [TW-1:0]  w_i;
  logic [TW-1:0]  w_j;
  logic           mac_clear;
  logic           mac_en;
  logic           result_we;
  logic [NKW-1:0] res_kernel;
  logic [XW-1:0]  res_x;
  logic [YW-1:0]  res_y;

  int checks = 0;
  int errors = 0;
  int stall_cyc [N_STALL] = '{20, 21, 35, 60, 61, 62, 100, 150, 200, 250};

  always #5 clk = ~clk;

  conv_sched #(
    .IMG_X    (IX),
    .IMG_Y    (IY),
    .KER      (K),
    .N_KERNEL (NK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .data_x     (data_x),
    .data_y     (data_y),
    .w_kernel   (w_kernel),
    .w_i        (w_i),
    .w_j        (w_j),
    .mac_clear  (mac_clear),
    .mac_en     (mac_en),
    .result_we  (result_we),
    .res_kernel (res_kernel),
    .res_x      (res_x),
    .res_y      (res_y)
  );

  // Full layer run starting with start high in the current cycle (cycle 0).
  // use_stall: drop mem_ready on the stall_cyc list; poke: extra start pulses
  // at cycle 50 and in the done cycle; chain: return at cycle done+1 so the
  // caller can launch the next run there.
  task automatic run_check(input string name, input bit use_stall, input bit poke, input bit chain);
    int  exp_done, n_iss, we_cnt, first_we, last_we;
    int  mk, mx, my, mi, mj, rk, rx, ry;
    bit  e_rd, e_mac, e_clr, e_we, s1_last, p_first, p_last, mr;
    exp_done = T + 3 + ((use_stall && STALL) ? N_STALL : 0);
    n_iss = 0; we_cnt = 0; first_we = -1; last_we = -1;
    mk = 0; mx = 0; my = 0; mi = 0; mj = 0; rk = 0; rx = 0; ry = 0;
    e_mac = 1'b0; e_clr = 1'b0; e_we = 1'b0; s1_last = 1'b0;
    start = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= exp_done + 1; c++) begin
      if (chain && c == exp_done + 1) break;
      mr = 1'b1;
      if (use_stall) begin
        for (int s = 0; s < N_STALL; s++) if (stall_cyc[s] == c) mr = 1'b0;
      end
      mem_ready = mr;
      start = poke && (c == 50 || c == exp_done);
      #2;
      e_rd = (n_iss < T) && (mr || !STALL);
      checks++;
      if (rd_en !== e_rd) begin
        errors++; $display("FAIL %s rd_en c=%0d got %b want %b", name, c, rd_en, e_rd);
      end
      if (e_rd) begin
        checks++;
        if (data_x !== DXW'(mx + mi) || data_y !== DYW'(my + mj) || w_kernel !== NKW'(mk) ||
            w_i !== TW'(mi) || w_j !== TW'(mj)) begin
          errors++;
          $display("FAIL %s addr c=%0d got x%0d y%0d k%0d i%0d j%0d want x%0d y%0d k%0d i%0d j%0d",
                   name, c, data_x, data_y, w_kernel, w_i, w_j, mx + mi, my + mj, mk, mi, mj);
        end
      end
      checks++;
      if (mac_en !== e_mac || mac_clear !== e_clr) begin
        errors++; $display("FAIL %s mac c=%0d got en%b clr%b want en%b clr%b", name, c, mac_en, mac_clear, e_mac, e_clr);
      end
      checks++;
      if (result_we !== e_we) begin
        errors++; $display("FAIL %s result_we c=%0d got %b want %b", name, c, result_we, e_we);
      end
      if (e_we && result_we) begin
        checks++;
        if (res_kernel !== NKW'(rk) || res_x !== XW'(rx) || res_y !== YW'(ry)) begin
          errors++; $display("FAIL %s res c=%0d got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                             name, c, res_kernel, res_x, res_y, rk, rx, ry);
        end
        ry++;
        if (ry == OY) begin ry = 0; rx++; if (rx == OX) begin rx = 0; rk++; end end
      end
      if (result_we === 1'b1) begin
        we_cnt++; if (first_we < 0) first_we = c; last_we = c;
      end
      checks++;
      if (busy !== (c < exp_done) || done !== (c == exp_done)) begin
        errors++; $display("FAIL %s busy/done c=%0d got %b/%b want %b/%b",
                           name, c, busy, done, (c < exp_done), (c == exp_done));
      end
      // Expectations for the next cycle.
      p_first = (mi == 0) && (mj == 0);
      p_last  = (mi == K - 1) && (mj == K - 1);
      e_we    = e_mac && s1_last;
      e_mac   = e_rd;
      e_clr   = e_rd && p_first;
      s1_last = e_rd && p_last;
      if (e_rd) begin
        n_iss++;
        mj++;
        if (mj == K) begin
          mj = 0; mi++;
          if (mi == K) begin
            mi = 0; my++;
            if (my == OY) begin my = 0; mx++; if (mx == OX) begin mx = 0; mk++; end end
          end
        end
      end
      @(posedge clk); #1;
    end
    if (!chain) start = 1'b0;
    mem_ready = 1'b1;
    checks++;
    if (we_cnt != NWIN || first_we != K * K + 2 || last_we != exp_done - 1) begin
      errors++; $display("FAIL %s we_summary got n%0d first%0d last%0d want n%0d first%0d last%0d",
                         name, we_cnt, first_we, last_we, NWIN, K * K + 2, exp_done - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done, rd_en, data_x, data_y, w_kernel, w_i, w_j, mac_clear, mac_en,
           result_we, res_kernel, res_x, res_y} !== '0) begin
        errors++; $display("FAIL reset_outs c=%0d got busy%b rd%b we%b want all 0", c, busy, rd_en, result_we);
      end
    end
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL reset_start c=%0d got busy%b rd%b done%b want 0 0 0", c, busy, rd_en, done);
      end
    end
  endtask

  task automatic test_nominal();
    run_check("nominal", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_check("busy_start", 1'b0, 1'b1, 1'b1);
    run_check("restart", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 100; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, rd_en, data_x, data_y, w_kernel, w_i, w_j, mac_clear, mac_en,
         result_we, res_kernel, res_x, res_y} !== '0) begin
      errors++; $display("FAIL mid_reset_outs got busy%b rd%b mac%b want all 0", busy, rd_en, mac_en);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if (rd_en !== 1'b0 || result_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL mid_reset_idle c=%0d got rd%b we%b done%b busy%b want 0", c, rd_en, result_we, done, busy);
      end
    end
    run_check("after_reset", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    run_check("stall", 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_ready = 1'b1;
    test_reset();
    test_nominal();
    test_start_while_busy();
    test_reset_mid_run();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
- Sequencer for a time-multiplexed convolution engine: walks every kernel, output position and filter tap.
- Issues one image/weight read per cycle, drives clear/enable to a single shared MAC, and strobes each finished sum into the result store.
- Sits between the top-level layer FSM (start/done handshake) and the data memory, weight memory, MAC and result memory.
- Replaces the fully parallel 8-kernel conv datapath with a serial, area-bounded one.

Parameters:
- IMG_X, 28, image rows
- IMG_Y, 28, image columns
- KER, 5, square kernel size (KER x KER taps)
- N_KERNEL, 8, number of kernels, processed sequentially
- Derived constants (not overridable): OUT_X = IMG_X-KER+1, OUT_Y = IMG_Y-KER+1, T = N_KERNEL*OUT_X*OUT_Y*KER*KER total taps.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to run a full layer
- mem_ready  in  1  read memories can accept a read this cycle (used only with CONV_SCHED_STALL_EN)
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, layer complete
- rd_en  out  1  read strobe for data and weight memories
- data_x  out  $clog2(IMG_X)  image row = x+i
- data_y  out  $clog2(IMG_Y)  image column = y+j
- w_kernel  out  $clog2(N_KERNEL)  weight bank select
- w_i, w_j  out  $clog2(KER) each  weight tap coordinates
- mac_clear  out  1  load product instead of accumulating (first tap of a window)
- mac_en  out  1  MAC operand valid
- result_we  out  1  write accumulated sum
- res_kernel, res_x, res_y  out  $clog2(N_KERNEL), $clog2(OUT_X), $clog2(OUT_Y)  result address

Behaviour:
- Reset: all outputs are 0; FSM is in IDLE; counters are 0. Reset mid-run aborts immediately, with no done pulse and no further result_we.
- FSM states:
  - IDLE: on start -> RUN. Counters are cleared, rd_en=1 next cycle.
  - RUN: issues taps. After the final tap is issued -> DRAIN.
  - DRAIN: waits for the pipeline to empty (2 cycles).
  - DONE: done=1 for one cycle -> IDLE.
- start outside IDLE is ignored.
- Loop order, outermost to innermost: kernel, x, y, i, j. Each counter wraps to 0 and carries to the next outer counter.
- Address outputs are registered and valid only when rd_en=1. data_x/y never exceed IMG-1.
- Pipeline (memory read latency fixed at 1):
  - Tap issued with rd_en in cycle c.
  - mac_en in cycle c+1. mac_clear=1 in c+1 iff that tap has i=0, j=0.
  - result_we in cycle c+2 iff that tap was i=KER-1, j=KER-1. res_* carry that tap's kernel/x/y, delayed to match.
- Timing without stall (start sampled at edge of cycle 0):
  - Tap n issued at cycle 1+n.
  - First result_we at cycle KER*KER+2.
  - Last result_we at cycle T+2.
  - done at cycle T+3.
  - busy high cycles 1..T+2, low in the done cycle.
- Exactly N_KERNEL*OUT_X*OUT_Y result_we pulses per run; each (kernel,x,y) is written once, in loop order.
- Start coinciding with reset: reset wins.

Optional Feature:
- Macro: CONV_SCHED_STALL_EN.
- Defined:
  - In RUN with mem_ready=0: rd_en=0 and counters hold.
  - Downstream pipeline stages keep draining; mac_en and result_we follow the delayed rd_en.
  - A stall adds exactly one cycle per low mem_ready cycle in RUN.
  - mem_ready is ignored in IDLE, DRAIN and DONE.
- Undefined: mem_ready port is present but unused; the scheduler never stalls.

Decomposition:
- Shared package conv_pkg:
  - IMG_X/IMG_Y/KER/N_KERNEL defaults and derived OUT_X/OUT_Y/T.
  - Counter width localparams.
  - State enum typedef (IDLE, RUN, DRAIN, DONE).
- One sub-module, conv_tap_cnt: the nested wrap/carry counter chain with an advance input. It outputs the counters, first_tap, last_tap and last_all.
- The top level holds the FSM and the 2-stage delay pipeline.

Test Plan:
All scenarios use small parameters IMG 6x6, KER 3, N_KERNEL 2, giving OUT 4x4 and T=288, unless stated.
1. Reset values: hold rst 3 cycles -> all outputs 0, busy=0. Pulse start during rst -> no run.
2. Nominal run, start at cycle 0:
   - rd_en at cycle 1 with all addresses 0.
   - mac_clear with mac_en at cycle 2.
   - First result_we at cycle 11 with res=(0,0,0).
   - Last result_we at cycle 290 with res=(1,3,3).
   - done pulse at cycle 291.
   - Exactly 32 result_we pulses.
   - Scoreboard data_x=x+i, data_y=y+j.
3. Start while busy (cycle 50) -> ignored, done still at 291. Start at cycle 291 -> ignored; start at 292 -> new run begins.
4. Reset mid-run at cycle 100 -> next cycle all outputs 0, state IDLE. A subsequent start reproduces scenario 2 timing.
5. With CONV_SCHED_STALL_EN, mem_ready low for 10 random cycles during RUN -> done at cycle 301, with an identical result_we address sequence.
6. Default parameters (28x28, KER 5, 8 kernels) -> done at cycle 115203, with 4608 result_we pulses.
